flash_burst_sequencer: RTL

Upstream command sequencer for the byte-wide flash controller in the multi-flash USB path. It accepts one host request (read burst, program burst, erase, ID or reset) and splits it into single-byte controller operations. For each operation it drives the controller's command, address, data and start inputs, waits on its ready output, streams read bytes out and pulls program bytes in. It gives the host a single request/done handshake, plus a timeout error.

---
 rtl/flash_burst_sequencer_pkg.sv | 31 +++
 rtl/flash_burst_sequencer_watchdog.sv | 45 ++++
 rtl/flash_burst_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/flash_burst_sequencer_pkg.sv
// Shared command codes and sequencer state encoding for the byte-wide flash path.
package flash_burst_sequencer_pkg;

   localparam logic [2:0] CMD_READ     = 3'd0;
   localparam logic [2:0] CMD_WRITE    = 3'd1;
   localparam logic [2:0] CMD_BLK_ERA  = 3'd2;
   localparam logic [2:0] CMD_SEC_ERA  = 3'd3;
   localparam logic [2:0] CMD_CHP_ERA  = 3'd4;
   localparam logic [2:0] CMD_ENTRY_ID = 3'd5;
   localparam logic [2:0] CMD_RESET    = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_FETCH,
      S_ISSUE,
      S_GUARD,
      S_WAIT_RDY,
      S_RD_HOLD,
      S_NEXT,
      S_DONE
   } state_t;

   function automatic logic is_burst(input logic [2:0] cmd);
      return (cmd == CMD_READ) || (cmd == CMD_WRITE);
   endfunction

   function automatic logic is_known(input logic [2:0] cmd);
      return cmd <= CMD_RESET;
   endfunction

endpackage

// File: rtl/flash_burst_sequencer_watchdog.sv
// Guard counter (ignore stale ready after a start edge) and ready timeout counter.
// guard_done/tmo are combinational compares on registered counts; no backpressure.
module flash_ready_watchdog #(
   parameter int               START_GUARD = 16,
   parameter int               TMO_W       = 24,
   parameter logic [TMO_W-1:0] TMO_CYCLES  = '1
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic guard_en,
   input  logic clear,
   input  logic tmo_en,
   output logic guard_done,
   output logic tmo
);

   localparam int               GW        = $clog2(START_GUARD + 1);
   localparam logic [GW-1:0]    GUARD_END = GW'(START_GUARD - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CYCLES - 1);

   logic [GW-1:0]    guard_cnt;
   logic [TMO_W-1:0] tmo_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         guard_cnt <= '0;
         tmo_cnt   <= '0;
      end else begin
         if (start)
            guard_cnt <= '0;
         else if (guard_en && !guard_done)
            guard_cnt <= guard_cnt + GW'(1);

         if (clear)
            tmo_cnt <= '0;
         else if (tmo_en && !tmo)
            tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   assign guard_done = (guard_cnt == GUARD_END);
   assign tmo        = (tmo_cnt == TMO_LAST);

endmodule

// File: rtl/flash_burst_sequencer.sv
// Splits one host request into single-byte flash controller operations with a request/done handshake.
// Per byte: 1 + START_GUARD + controller time + 1 cycles (+1 for WRITE); read bytes held until rd_ready.
module flash_burst_sequencer
   import flash_burst_sequencer_pkg::*;
#(
   parameter int               START_GUARD = 16,
   parameter int               TMO_W       = 24,
   parameter logic [TMO_W-1:0] TMO_CYCLES  = 24'hFFFFFF
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_cmd,
   input  logic [19:0] req_addr,
   input  logic [19:0] req_len,
   input  logic        wr_valid,
   input  logic [7:0]  wr_data,
   output logic        wr_ready,
   output logic        rd_valid,
   output logic [7:0]  rd_data,
   input  logic        rd_ready,
   output logic        done,
   output logic        err,
   output logic        busy,
   output logic [2:0]  fl_cmd,
   output logic [19:0] fl_addr,
   output logic [7:0]  fl_wdata,
   output logic        fl_start,
   input  logic [7:0]  fl_rdata,
   input  logic        fl_ready
);

   state_t      state, state_d;
   logic [2:0]  cmd_q;
   logic [19:0] addr_q;
   logic [19:0] rem_q;
   logic [7:0]  wdata_q;
   logic [7:0]  rd_data_q;
   logic        err_q;
   logic        accept;
   logic        guard_done;
   logic        tmo;
   logic        wd_start, wd_guard, wd_tmo_en;

   assign accept = req_valid && req_ready;

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:
            if (accept) begin
               if (!is_known(req_cmd))
                  state_d = S_DONE;
               else if (req_cmd == CMD_WRITE)
                  state_d = S_WR_FETCH;
               else
                  state_d = S_ISSUE;
            end
         S_WR_FETCH: if (wr_valid) state_d = S_ISSUE;
         S_ISSUE:    state_d = S_GUARD;
         S_GUARD:    if (guard_done) state_d = S_WAIT_RDY;
         S_WAIT_RDY:
            if (fl_ready)
               state_d = (cmd_q == CMD_READ) ? S_RD_HOLD : S_NEXT;
            else if (tmo)
               state_d = S_DONE;
         S_RD_HOLD:  if (rd_ready) state_d = S_NEXT;
         S_NEXT:
            if (rem_q == '0)
               state_d = S_DONE;
            else
               state_d = (cmd_q == CMD_WRITE) ? S_WR_FETCH : S_ISSUE;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state     <= S_IDLE;
         cmd_q     <= '0;
         addr_q    <= '0;
         rem_q     <= '0;
         wdata_q   <= '0;
         rd_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state <= state_d;
         case (state)
            S_IDLE:
               if (accept) begin
                  cmd_q  <= req_cmd;
                  addr_q <= req_addr;
                  rem_q  <= is_burst(req_cmd) ? req_len : '0;
                  err_q  <= !is_known(req_cmd);
               end
            S_WR_FETCH:
               if (wr_valid) wdata_q <= wr_data;
            S_WAIT_RDY:
               if (fl_ready) begin
                  if (cmd_q == CMD_READ) rd_data_q <= fl_rdata;
               end else if (tmo) begin
                  err_q <= 1'b1;
               end
            S_NEXT:
               if (rem_q != '0) begin
                  addr_q <= addr_q + 20'd1;
                  rem_q  <= rem_q - 20'd1;
               end
            S_DONE:
               err_q <= 1'b0;
            default: ;
         endcase
      end
   end

   // The timeout count is held clear for the whole guard window, so it starts at zero on WAIT_RDY entry.
   assign wd_start  = (state == S_ISSUE);
   assign wd_guard  = (state == S_GUARD);
   assign wd_tmo_en = (state == S_WAIT_RDY);

   flash_ready_watchdog #(
      .START_GUARD (START_GUARD),
      .TMO_W       (TMO_W),
      .TMO_CYCLES  (TMO_CYCLES)
   ) u_watchdog (
      .clk        (iCLK),
      .rst        (iRST),
      .start      (wd_start),
      .guard_en   (wd_guard),
      .clear      (wd_guard),
      .tmo_en     (wd_tmo_en),
      .guard_done (guard_done),
      .tmo        (tmo)
   );

   assign req_ready = (state == S_IDLE) && fl_ready;
   assign wr_ready  = (state == S_WR_FETCH) && wr_valid;
   assign fl_start  = (state == S_ISSUE) || (state == S_GUARD);
   assign rd_valid  = (state == S_RD_HOLD);
   assign rd_data   = rd_data_q;
   assign done      = (state == S_DONE);
   assign err       = done && err_q;
   assign busy      = (state != S_IDLE);
   assign fl_cmd    = cmd_q;
   assign fl_addr   = addr_q;
   assign fl_wdata  = wdata_q;

endmodule
